// File: rtl/pipe_pkg.sv
// Shared definitions for the hazard/forwarding block of the 5-stage RV64I pipeline.
// Provides:
//   - FWD_RF / FWD_WB / FWD_MEM : operand-select encodings driven to the execute stage
//   - REG_AW                    : register-index width
//   - pipe_tag                  : per-stage shadow tag {valid, rd, reg_write, mem_read, rs1, rs2}
//   - TAG_BUBBLE                : all-zero tag used to insert a bubble
//   - is_writer()               : a stage that really writes a non-x0 register
package pipe_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } pipe_tag;

  localparam pipe_tag TAG_BUBBLE = '0;

  // x0 is hard-wired to zero, so a write to it never produces a value worth forwarding.
  function automatic logic is_writer(input pipe_tag t);
    return t.valid & t.reg_write & (t.rd != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// fwd_select: combinational operand-source select for one EX source register.
// Ports:
//   src_reg  in  REG_AW  source register of the instruction in EX
//   mem_tag  in  tag     shadow tag of the instruction in MEM
//   wb_tag   in  tag     shadow tag of the instruction in WB
//   sel      out 2       FWD_MEM, FWD_WB or FWD_RF
module fwd_select
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] src_reg,
  input  pipe_tag           mem_tag,
  input  pipe_tag           wb_tag,
  output logic [1:0]        sel
);

  // Source-register fields of the MEM/WB tags play no part in forwarding.
  logic unused_tag_bits;
  assign unused_tag_bits = ^{mem_tag.rs1, mem_tag.rs2, wb_tag.rs1, wb_tag.rs2, wb_tag.mem_read};

  // MEM wins over WB because it holds the younger value; a load in MEM has no data yet.
  always_comb begin
    sel = FWD_RF;
    if (is_writer(mem_tag) && !mem_tag.mem_read && (mem_tag.rd == src_reg)) begin
      sel = FWD_MEM;
    end else if (is_writer(wb_tag) && (wb_tag.rd == src_reg)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: forwarding selects, load-use stall and branch flush for the
// 5-stage RV64I pipeline, with stall/flush performance counters.
// Ports:
//   clk, reset                 pipeline clock (rising edge), synchronous active-high reset
//   id_valid, id_rs1, id_rs2,  tags of the instruction currently in ID
//   id_rd, id_reg_write,
//   id_mem_read
//   PCSrc                      taken-branch indication from EX (same cycle)
//   ForwardA, ForwardB         operand selects for EX (00 RF, 10 MEM, 01 WB)
//   stall                      hold PC and IF/ID, bubble into ID/EX
//   flush                      squash IF/ID and ID/EX
//   stall_count, flush_count   free-running wrap-around cycle counters
// The shadow tag struct width comes from pipe_pkg::REG_AW; the REG_AW parameter
// must be left at its default so the ports agree with the tag fields.
module hazard_forward_unit #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              PCSrc,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  import pipe_pkg::*;

  pipe_tag    ex_tag;
  pipe_tag    mem_tag;
  pipe_tag    wb_tag;
  pipe_tag    id_tag;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_use;

  // Gather the ID-stage fields into a tag ready to enter EX.
  always_comb begin
    id_tag           = TAG_BUBBLE;
    id_tag.valid     = id_valid;
    id_tag.rd        = id_rd;
    id_tag.reg_write = id_reg_write;
    id_tag.mem_read  = id_mem_read;
    id_tag.rs1       = id_rs1;
    id_tag.rs2       = id_rs2;
  end

  fwd_select u_fwd_a (
    .src_reg (ex_tag.rs1),
    .mem_tag (mem_tag),
    .wb_tag  (wb_tag),
    .sel     (sel_a)
  );

  fwd_select u_fwd_b (
    .src_reg (ex_tag.rs2),
    .mem_tag (mem_tag),
    .wb_tag  (wb_tag),
    .sel     (sel_b)
  );

  // Load in EX whose destination is read by the valid instruction in ID.
  always_comb begin
    load_use = ex_tag.valid & ex_tag.mem_read & (ex_tag.rd != {REG_AW{1'b0}}) & id_valid &
               ((ex_tag.rd == id_rs1) | (ex_tag.rd == id_rs2));
  end

  // Control outputs; a flush overrides a stall so a squashed consumer never freezes the PC.
  always_comb begin
    ForwardA = FWD_RF;
    ForwardB = FWD_RF;
    stall    = 1'b0;
    flush    = 1'b0;
    if (!reset) begin
      flush = ex_tag.valid & PCSrc;
      stall = load_use & ~flush;
      if (ex_tag.valid) begin
        ForwardA = sel_a;
        ForwardB = sel_b;
      end else begin
        ForwardA = FWD_RF;
        ForwardB = FWD_RF;
      end
    end else begin
      ForwardA = FWD_RF;
      ForwardB = FWD_RF;
    end
  end

  // Shadow tag pipeline advancing in lock-step with the datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_tag  <= TAG_BUBBLE;
      mem_tag <= TAG_BUBBLE;
      wb_tag  <= TAG_BUBBLE;
    end else begin
      wb_tag  <= mem_tag;
      mem_tag <= ex_tag;
      if (flush || stall) begin
        ex_tag <= TAG_BUBBLE;
      end else begin
        ex_tag <= id_tag;
      end
    end
  end

  // Performance counters; wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= {CNT_W{1'b0}};
      flush_count <= {CNT_W{1'b0}};
    end else begin
      if (stall) begin
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_count <= stall_count;
      end
      if (flush) begin
        flush_count <= flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_count <= flush_count;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: each stimulus cycle pushes its hand-computed
// expected outputs; a monitor pops and compares them at the falling edge of that cycle.
module tb_hazard_forward_unit;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        PCSrc;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        stall;
  logic        flush;
  logic [31:0] stall_count;
  logic [31:0] flush_count;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic        fl;
    logic        chk_cnt;
    logic [31:0] sc;
    logic [31:0] fc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  hazard_forward_unit #(.CNT_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .PCSrc        (PCSrc),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .stall        (stall),
    .flush        (flush),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, exp);
    end
  endtask

  // Monitor: outputs are compared at the falling edge of the cycle they were issued in.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "ForwardA", {30'd0, ForwardA}, {30'd0, e.fa});
        check(e.name, "ForwardB", {30'd0, ForwardB}, {30'd0, e.fb});
        check(e.name, "stall", {31'd0, stall}, {31'd0, e.st});
        check(e.name, "flush", {31'd0, flush}, {31'd0, e.fl});
        if (e.chk_cnt) begin
          check(e.name, "stall_count", stall_count, e.sc);
          check(e.name, "flush_count", flush_count, e.fc);
        end
      end
    end
  end

  // One pipeline cycle: apply ID-stage inputs and queue the expected response.
  task automatic step(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic rw, input logic mr, input logic pc,
                      input logic [1:0] efa, input logic [1:0] efb, input logic est,
                      input logic efl, input logic chk, input logic [31:0] esc,
                      input logic [31:0] efc, input string nm);
    exp_t e;
    reset        = r;
    id_valid     = v;
    id_rs1       = s1;
    id_rs2       = s2;
    id_rd        = d;
    id_reg_write = rw;
    id_mem_read  = mr;
    PCSrc        = pc;
    e.fa = efa; e.fb = efb; e.st = est; e.fl = efl;
    e.chk_cnt = chk; e.sc = esc; e.fc = efc; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0,
           2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "idle");
    end
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; PCSrc = 1'b0;
    @(posedge clk);
    #1;
    //    r     v     rs1    rs2    rd     rw    mr    pc     FA     FB    st    fl   chk  scnt   fcnt
    step(1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "rst0");
    step(1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "rst1");
    // add x5,x1,x2 ; sub x6,x5,x3 -> MEM forward on A
    step(1'b0, 1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t1_add_id");
    step(1'b0, 1'b1, 5'd5,  5'd3,  5'd6,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t1_sub_id");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "t1_sub_ex");
    idle(3);
    // add x5 ; nop ; or x7,x4,x5 -> WB forward on B
    step(1'b0, 1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t2_add_id");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t2_nop_id");
    step(1'b0, 1'b1, 5'd4,  5'd5,  5'd7,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t2_or_id");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "t2_or_ex");
    idle(3);
    // ld x8,0(x1) ; add x9,x8,x8 -> one stall, then WB forward on both
    step(1'b0, 1'b1, 5'd1,  5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "t3_ld_id");
    step(1'b0, 1'b1, 5'd8,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0, "t3_stall");
    step(1'b0, 1'b1, 5'd8,  5'd8,  5'd9,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0, "t3_held");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0, "t3_add_ex");
    idle(3);
    // addi x0,x0,5 ; add x3,x0,x0 -> x0 never forwarded
    step(1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t4_addi_x0");
    step(1'b0, 1'b1, 5'd0,  5'd0,  5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t4_add_x0_id");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t4_add_x0_ex");
    idle(3);
    // add x5 ; add x5 ; use x5 -> MEM has priority over WB
    step(1'b0, 1'b1, 5'd1,  5'd2,  5'd5,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t4_add5a");
    step(1'b0, 1'b1, 5'd3,  5'd4,  5'd5,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t4_add5b");
    step(1'b0, 1'b1, 5'd5,  5'd5,  5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t4_use_id");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0, "t4_mem_prio");
    idle(3);
    // load in EX with taken branch while ID holds its consumer -> flush wins
    step(1'b0, 1'b1, 5'd1,  5'd0,  5'd8,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0, "t5_ld_id");
    step(1'b0, 1'b1, 5'd8,  5'd8,  5'd9,  1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 32'd1, 32'd0, "t5_flush_wins");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, "t5_bubble");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, "t5_pcsrc_no_ex");
    idle(3);
    // three writers in flight, then a one-cycle reset
    step(1'b0, 1'b1, 5'd0,  5'd0,  5'd1,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t6_w1");
    step(1'b0, 1'b1, 5'd1,  5'd1,  5'd2,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, "t6_w2");
    step(1'b0, 1'b1, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, "t6_w3");
    step(1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, "t6_reset");
    step(1'b0, 1'b1, 5'd1,  5'd2,  5'd4,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "t6_after_rst");
    step(1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, "t6_first_ex");

    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
